fighter_motion: RTL
===================

Name: fighter_motion

Overview:
- Parametrised per-fighter motion controller; one instance per fighter (SIDE=0 player, SIDE=1 enemy).
- Converts decoded controller intents into screen-space position and pose flags, which feed the renderer and hit-detection logic.
- Adds frame-tick gating, dash with cooldown, hit-stun with knockback, blocked-hit pushback and airborne stun to the single-speed walk/jump/squat/defend scheme.

Parameters:
- SIDE, 0: spawn side. 0 spawns at X_MIN facing right; 1 spawns at X_MAX facing left.
- X_MIN, -256: left clamp of x.
- X_MAX, 256: right clamp of x.
- GROUND_Y, -144: y while grounded.
- STEP_X, 4: walk displacement per tick.
- DASH_X, 12: dash displacement per tick.
- DASH_LEN, 4: dash duration in ticks.
- DASH_CD, 8: ticks after dash end before the next dash is accepted.
- V, 20: jump launch velocity.
- G, 2: gravity.
- MAX_J, 20: jump frame count.
- KB_X, 6: knockback displacement per stun tick.
- STUN_LEN, 8: stun duration in ticks.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse; motion advances only on tick cycles
- right  in  1  walk/dash right intent
- left  in  1  walk/dash left intent
- jump  in  1  jump intent
- squat  in  1  squat intent
- defend  in  1  guard intent
- dash  in  1  dash intent
- hit  in  1  one-cycle hit pulse from hit detection; may arrive on any cycle
- hit_from_right  in  1  attacker is to the right; knockback is pushed left
- x  out  11 signed  position
- y  out  10 signed  position
- isD  out  1  guarding
- isQ  out  1  squatting
- isJ  out  1  airborne
- isH  out  1  in hit-stun
- facing_r  out  1  1 = facing right

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - x = X_MIN if SIDE=0, else X_MAX; y = GROUND_Y.
  - State GROUND; all counters 0; hit_pend=0; isJ=isH=0.
  - facing_r = ~SIDE.
  - Reset mid-jump, mid-dash or mid-stun aborts immediately.
- Hit latching:
  - hit sets hit_pend on any cycle.
  - hit_pend is consumed (cleared) on the next frame_tick cycle. If hit and frame_tick coincide, the hit takes effect on that tick.
- State register: GROUND, JUMP, DASH, STUN. All updates below happen only when frame_tick=1; otherwise every register holds.
- Priority per tick: pending hit > dash > jump > walk.
- GROUND:
  - Walk: right → x += STEP_X; else left → x -= STEP_X. Suppressed while defend or squat is held.
  - jump → JUMP with jcnt=0.
  - dash with right^left, and dash cooldown counter dcd=0 → DASH, direction latched, dcnt=0.
- JUMP:
  - y = GROUND_Y + V*jcnt − (G*jcnt*jcnt)/2, using the pre-increment jcnt. Computed in 16-bit signed, clamped to ≥ GROUND_Y, then truncated to 10 bits.
  - If jcnt ≥ MAX_J: → GROUND, jcnt=0, y=GROUND_Y. Else jcnt++.
  - Horizontal walk is allowed at STEP_X. jump and dash are ignored.
- DASH:
  - x moves DASH_X per tick in the latched direction.
  - dcnt++; on dcnt = DASH_LEN−1 → GROUND with dcd = DASH_CD.
  - dcd decrements once per tick in any state until it reaches 0.
- Hit, unguarded (not GROUND with defend, or any other state):
  - → STUN, scnt=0; any dash is cancelled.
  - x moves KB_X per tick away from the attacker for STUN_LEN ticks.
  - If airborne, jcnt keeps advancing and y follows the arc. A hit during STUN restarts scnt.
  - Exit when scnt = STUN_LEN−1: → JUMP if the arc is unfinished, else GROUND.
- Hit, guarded (GROUND && defend): no state change; x moves KB_X/2 once, away from the attacker.
- Clamping: after every x update, x is clamped to [X_MIN, X_MAX]. No wrap-around.
- Outputs:
  - isD = defend && state==GROUND && !squat.
  - isQ = squat && state==GROUND.
  - isJ = airborne (JUMP, or STUN with an arc in progress).
  - isH = (state==STUN).
  - facing_r updates on the tick when walking right/left in GROUND; it is held otherwise.
- Latency: x/y/flags reflect a tick's inputs one clk after that tick.

Decomposition:
- game_pkg holds:
  - the state enum (fm_state_t);
  - constants X_MIN, X_MAX, GROUND_Y, STEP_X, V, G, MAX_J, KB_X, STUN_LEN, DASH_*, used as parameter defaults.
- One sub-module: jump_arc. It is combinational: jcnt in, clamped y out. It is shared with the projectile block.

Test Plan:
- Reset with SIDE=1, hold 3 ticks with no input → x=256, y=−144, all flags 0, facing_r=0.
- SIDE=0, right held 5 ticks → x=−236. Then left held 70 ticks → x clamps at −256 with no wrap.
- Jump pulse, then 22 ticks → y=−144 and −144, then −125, …, peak −44 at jcnt=10, back to −144. isJ drops after the 22nd tick.
- Dash right from x=0 → x=12, 24, 36, 48. A dash retried 3 ticks later is ignored. After 8 ticks of cooldown, dash is accepted again.
- Hit (hit_from_right=1) at the 5th jump tick, off-tick pulse → on the next tick isH=1; x −6 per tick for 8 ticks; y continues the arc; state returns to JUMP.
- Guarded hit at x=0 → x=−3, isH stays 0. Reset asserted mid-stun → next cycle the reset values are restored.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared fighter motion types and default tuning constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Motion state of one fighter
  typedef enum logic [1:0] {
    GROUND = 2'd0,
    JUMP   = 2'd1,
    DASH   = 2'd2,
    STUN   = 2'd3
  } fm_state_t;

  localparam int X_MIN    = -256;
  localparam int X_MAX    = 256;
  localparam int GROUND_Y = -144;
  localparam int STEP_X   = 4;
  localparam int DASH_X   = 12;
  localparam int DASH_LEN = 4;
  localparam int DASH_CD  = 8;
  localparam int V        = 20;
  localparam int G        = 2;
  localparam int MAX_J    = 20;
  localparam int KB_X     = 6;
  localparam int STUN_LEN = 8;
  // Jump frame counter width, large enough for MAX_J
  localparam int JCNT_W   = 6;

endpackage
`default_nettype wire

// File: rtl/jump_arc.sv
`default_nettype none
// ============================================================================
//  Module      : jump_arc
//  Description : Combinational ballistic height for a jump frame count,
//                clamped so it never drops below ground level.
//  Revision    : 1.0 - initial release
// ============================================================================
module jump_arc #(
  parameter int JCNT_W   = game_pkg::JCNT_W,
  parameter int GROUND_Y = game_pkg::GROUND_Y,
  parameter int V        = game_pkg::V,
  parameter int G        = game_pkg::G
) (
  input  logic [JCNT_W-1:0] jcnt,
  output logic signed [9:0] y
);

  localparam logic signed [15:0] c_ground_y = 16'(GROUND_Y);
  localparam logic signed [15:0] c_v        = 16'(V);
  localparam logic signed [15:0] c_g        = 16'(G);

  logic signed [15:0] w_j;
  logic signed [15:0] w_raw;

  // y = ground + V*j - G*j^2/2, evaluated wide then clamped to ground
  always_comb begin
    w_j   = {{(16-JCNT_W){1'b0}}, jcnt};
    w_raw = c_ground_y + c_v * w_j - (c_g * w_j * w_j) / 16'sd2;
    y     = (w_raw < c_ground_y) ? c_ground_y[9:0] : w_raw[9:0];
  end

endmodule
`default_nettype wire

// File: rtl/fighter_motion.sv
`default_nettype none
// ============================================================================
//  Module      : fighter_motion
//  Description : Per-fighter motion controller. Turns decoded intents into
//                screen position and pose flags: walk, jump arc, dash with
//                cooldown, hit-stun with knockback and guarded pushback.
//  Revision    : 1.0 - initial release
// ============================================================================
module fighter_motion #(
  parameter int SIDE     = 0,
  parameter int X_MIN    = game_pkg::X_MIN,
  parameter int X_MAX    = game_pkg::X_MAX,
  parameter int GROUND_Y = game_pkg::GROUND_Y,
  parameter int STEP_X   = game_pkg::STEP_X,
  parameter int DASH_X   = game_pkg::DASH_X,
  parameter int DASH_LEN = game_pkg::DASH_LEN,
  parameter int DASH_CD  = game_pkg::DASH_CD,
  parameter int V        = game_pkg::V,
  parameter int G        = game_pkg::G,
  parameter int MAX_J    = game_pkg::MAX_J,
  parameter int KB_X     = game_pkg::KB_X,
  parameter int STUN_LEN = game_pkg::STUN_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               right,
  input  logic               left,
  input  logic               jump,
  input  logic               squat,
  input  logic               defend,
  input  logic               dash,
  input  logic               hit,
  input  logic               hit_from_right,
  output logic signed [10:0] x,
  output logic signed [9:0]  y,
  output logic               isD,
  output logic               isQ,
  output logic               isJ,
  output logic               isH,
  output logic               facing_r
);

  import game_pkg::*;

  localparam int JW = game_pkg::JCNT_W;

  localparam logic signed [12:0] c_x_min   = 13'(X_MIN);
  localparam logic signed [12:0] c_x_max   = 13'(X_MAX);
  localparam logic signed [12:0] c_step    = 13'(STEP_X);
  localparam logic signed [12:0] c_dash    = 13'(DASH_X);
  localparam logic signed [12:0] c_kb      = 13'(KB_X);
  localparam logic signed [12:0] c_kb_half = 13'(KB_X / 2);
  localparam logic signed [10:0] c_x_min11 = 11'(X_MIN);
  localparam logic signed [10:0] c_x_max11 = 11'(X_MAX);
  localparam logic signed [10:0] c_x_rst   = (SIDE != 0) ? 11'(X_MAX) : 11'(X_MIN);
  localparam logic signed [9:0]  c_ground  = 10'(GROUND_Y);
  localparam logic [7:0]         c_dash_last = 8'(DASH_LEN - 1);
  localparam logic [7:0]         c_dash_cd   = 8'(DASH_CD);
  localparam logic [7:0]         c_stun_last = 8'(STUN_LEN - 1);
  localparam logic [JW-1:0]      c_max_j     = JW'(MAX_J);
  localparam logic               c_face_rst  = (SIDE == 0);

  fm_state_t          r_state, w_state_n;
  logic signed [10:0] r_x, w_x_n;
  logic signed [9:0]  r_y, w_y_n;
  logic [JW-1:0]      r_jcnt, w_jcnt_n;
  logic [7:0]         r_dcnt, w_dcnt_n;
  logic [7:0]         r_scnt, w_scnt_n;
  logic [7:0]         r_dcd, w_dcd_n;
  logic               r_dash_r, w_dash_r_n;
  logic               r_air, w_air_n;
  logic               r_face, w_face_n;
  logic               r_isd, w_isd_n;
  logic               r_isq, w_isq_n;
  logic               r_hit_pend, r_hit_dir;

  logic               w_hit, w_kb_left, w_arc_done, w_arc_air;
  logic [JW-1:0]      w_arc_jcnt;
  logic signed [9:0]  w_arc_y, w_arc_y_n;
  logic signed [12:0] w_dx, w_walk_dx, w_xsum;

  jump_arc #(
    .JCNT_W   (JW),
    .GROUND_Y (GROUND_Y),
    .V        (V),
    .G        (G)
  ) u_arc (
    .jcnt (r_jcnt),
    .y    (w_arc_y)
  );

  // A hit coinciding with the tick is honoured on that tick with its own side
  assign w_hit      = r_hit_pend | hit;
  assign w_kb_left  = hit ? hit_from_right : r_hit_dir;
  assign w_walk_dx  = right ? c_step : (left ? -c_step : 13'sd0);

  // One frame of airborne motion: follow the arc, land once it is complete
  assign w_arc_done = (r_jcnt >= c_max_j);
  assign w_arc_jcnt = w_arc_done ? '0 : r_jcnt + 1'b1;
  assign w_arc_y_n  = w_arc_done ? c_ground : w_arc_y;
  assign w_arc_air  = !w_arc_done;

  // Next-state and datapath for one frame tick
  always_comb begin
    w_state_n  = r_state;
    w_jcnt_n   = r_jcnt;
    w_dcnt_n   = r_dcnt;
    w_scnt_n   = r_scnt;
    w_y_n      = r_y;
    w_air_n    = r_air;
    w_dash_r_n = r_dash_r;
    w_face_n   = r_face;
    w_dcd_n    = (r_dcd != 8'd0) ? r_dcd - 8'd1 : r_dcd;
    w_dx       = 13'sd0;

    case (r_state)
      GROUND: begin
        if (w_hit && defend) begin
          w_dx = w_kb_left ? -c_kb_half : c_kb_half;
        end else if (w_hit) begin
          w_state_n = STUN;
          w_scnt_n  = 8'd0;
          w_air_n   = 1'b0;
        end else if (dash && (right ^ left) && (r_dcd == 8'd0)) begin
          w_state_n  = DASH;
          w_dcnt_n   = 8'd0;
          w_dash_r_n = right;
        end else if (jump) begin
          w_state_n = JUMP;
          w_jcnt_n  = '0;
          w_air_n   = 1'b1;
        end else if (!defend && !squat) begin
          w_dx = w_walk_dx;
          if (right)     w_face_n = 1'b1;
          else if (left) w_face_n = 1'b0;
        end
      end

      JUMP: begin
        w_jcnt_n = w_arc_jcnt;
        w_y_n    = w_arc_y_n;
        w_air_n  = w_arc_air;
        if (w_hit) begin
          w_state_n = STUN;
          w_scnt_n  = 8'd0;
        end else begin
          w_dx = w_walk_dx;
          if (w_arc_done) w_state_n = GROUND;
        end
      end

      DASH: begin
        if (w_hit) begin
          w_state_n = STUN;
          w_scnt_n  = 8'd0;
          w_air_n   = 1'b0;
          w_dcnt_n  = 8'd0;
        end else begin
          w_dx = r_dash_r ? c_dash : -c_dash;
          if (r_dcnt == c_dash_last) begin
            w_state_n = GROUND;
            w_dcnt_n  = 8'd0;
            w_dcd_n   = c_dash_cd;
          end else begin
            w_dcnt_n = r_dcnt + 8'd1;
          end
        end
      end

      STUN: begin
        w_dx = w_kb_left ? -c_kb : c_kb;
        if (r_air) begin
          w_jcnt_n = w_arc_jcnt;
          w_y_n    = w_arc_y_n;
          w_air_n  = w_arc_air;
        end
        if (w_hit) begin
          w_scnt_n = 8'd0;
        end else if (r_scnt == c_stun_last) begin
          w_scnt_n  = 8'd0;
          w_state_n = w_air_n ? JUMP : GROUND;
        end else begin
          w_scnt_n = r_scnt + 8'd1;
        end
      end

      default: w_state_n = GROUND;
    endcase

    // Saturate at the arena edges rather than wrapping
    w_xsum = {{2{r_x[10]}}, r_x} + w_dx;
    if (w_xsum < c_x_min)      w_x_n = c_x_min11;
    else if (w_xsum > c_x_max) w_x_n = c_x_max11;
    else                       w_x_n = w_xsum[10:0];

    w_isd_n = defend && !squat && (w_state_n == GROUND);
    w_isq_n = squat && (w_state_n == GROUND);
  end

  // State register, advancing only on frame ticks
  always_ff @(posedge clk) begin
    if (!rst_n)          r_state <= GROUND;
    else if (frame_tick) r_state <= w_state_n;
  end

  // Motion datapath registers, advancing only on frame ticks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x      <= c_x_rst;
      r_y      <= c_ground;
      r_jcnt   <= '0;
      r_dcnt   <= 8'd0;
      r_scnt   <= 8'd0;
      r_dcd    <= 8'd0;
      r_dash_r <= 1'b0;
      r_air    <= 1'b0;
      r_face   <= c_face_rst;
      r_isd    <= 1'b0;
      r_isq    <= 1'b0;
    end else if (frame_tick) begin
      r_x      <= w_x_n;
      r_y      <= w_y_n;
      r_jcnt   <= w_jcnt_n;
      r_dcnt   <= w_dcnt_n;
      r_scnt   <= w_scnt_n;
      r_dcd    <= w_dcd_n;
      r_dash_r <= w_dash_r_n;
      r_air    <= w_air_n;
      r_face   <= w_face_n;
      r_isd    <= w_isd_n;
      r_isq    <= w_isq_n;
    end
  end

  // Hits may land between ticks; hold them until the next tick consumes them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_pend <= 1'b0;
      r_hit_dir  <= 1'b0;
    end else begin
      if (hit) r_hit_dir <= hit_from_right;
      if (frame_tick) r_hit_pend <= 1'b0;
      else if (hit)   r_hit_pend <= 1'b1;
    end
  end

  assign x        = r_x;
  assign y        = r_y;
  assign isD      = r_isd;
  assign isQ      = r_isq;
  assign isJ      = (r_state == JUMP) || ((r_state == STUN) && r_air);
  assign isH      = (r_state == STUN);
  assign facing_r = r_face;

endmodule
`default_nettype wire
